// File: rtl/shade_output_fifo_pkg.sv
// Shared types for the shade output path: packed pixel and raster coordinate widths.
// Colour and screen geometry defaults come from the common defines when present.
`ifndef COLOR_WIDTH
`define COLOR_WIDTH 8
`endif
`ifndef SCREEN_WIDTH
`define SCREEN_WIDTH 640
`endif
`ifndef SCREEN_HEIGHT
`define SCREEN_HEIGHT 480
`endif

package shade_output_fifo_pkg;

  localparam int X_W = 10;
  localparam int Y_W = 9;

  typedef logic [X_W-1:0] x_t;
  typedef logic [Y_W-1:0] y_t;

  typedef struct packed {
    logic [`COLOR_WIDTH-1:0] r;
    logic [`COLOR_WIDTH-1:0] g;
    logic [`COLOR_WIDTH-1:0] b;
  } pixel_t;

endpackage

// File: rtl/sync_fifo_fwft.sv
// First-word-fall-through FIFO, 1-cycle write-to-head latency, registered head.
// No internal drop protection: caller must not assert wr_en when full (unless popping) or rd_en when empty.
module sync_fifo_fwft #(
  parameter int WIDTH = 24,
  parameter int DEPTH = 64,
  localparam int AW = $clog2(DEPTH),
  localparam int LW = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  output logic [WIDTH-1:0] rd_data,
  output logic             rd_valid,
  output logic [LW-1:0]    level,
  output logic             full
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW-1:0]    rd_ptr_nxt;
  logic [LW-1:0]    level_nxt;

  always_comb begin
    rd_ptr_nxt = rd_ptr + AW'(rd_en);
    level_nxt  = level + LW'(wr_en) - LW'(rd_en);
  end

  assign full = (level == LW'(DEPTH));

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr] <= wr_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      level    <= '0;
      rd_valid <= 1'b0;
      rd_data  <= '0;
    end else begin
      wr_ptr   <= wr_ptr + AW'(wr_en);
      rd_ptr   <= rd_ptr_nxt;
      level    <= level_nxt;
      rd_valid <= (level_nxt != '0);
      // Next head comes from memory, except when the entry being written is itself the next head.
      if (level_nxt != '0)
        rd_data <= (wr_en && (wr_ptr == rd_ptr_nxt)) ? wr_data : mem[rd_ptr_nxt];
    end
  end

endmodule

// File: rtl/shade_output_fifo.sv
// Shading-to-packer elastic FIFO with raster sof/eol tagging; 1-cycle latency in to out.
// Input has no backpressure: almost_full throttles ray issue, pixels arriving when full are dropped and flagged.
`ifndef COLOR_WIDTH
`define COLOR_WIDTH 8
`endif
`ifndef SCREEN_WIDTH
`define SCREEN_WIDTH 640
`endif
`ifndef SCREEN_HEIGHT
`define SCREEN_HEIGHT 480
`endif

module shade_output_fifo
  import shade_output_fifo_pkg::*;
#(
  parameter int DEPTH         = 64,
  parameter int COLOR_WIDTH   = `COLOR_WIDTH,
  parameter int SCREEN_WIDTH  = `SCREEN_WIDTH,
  parameter int SCREEN_HEIGHT = `SCREEN_HEIGHT,
  parameter int AFULL_MARGIN  = 16,
  localparam int PW = 3 * COLOR_WIDTH,
  localparam int LW = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  input  logic [PW-1:0] in_pixel,
  output logic [PW-1:0] out_pixel,
  output logic          out_valid,
  input  logic          out_ready,
  output logic          out_sof,
  output logic          out_eol,
  output logic          almost_full,
  output logic          overflow,
  output logic          frame_done,
  output logic [LW-1:0] level
);

  logic          push;
  logic          pop;
  logic          fifo_full;
  logic [LW-1:0] level_nxt;
  x_t            x;
  y_t            y;
  logic          last_x;
  logic          last_y;

  assign pop       = out_valid & out_ready;
  assign push      = in_valid & (~fifo_full | pop);
  assign level_nxt = level + LW'(push) - LW'(pop);

  assign last_x  = (x == X_W'(SCREEN_WIDTH - 1));
  assign last_y  = (y == Y_W'(SCREEN_HEIGHT - 1));
  assign out_sof = (x == '0) && (y == '0);
  assign out_eol = last_x;

  sync_fifo_fwft #(
    .WIDTH (PW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .wr_en    (push),
    .wr_data  (in_pixel),
    .rd_en    (pop),
    .rd_data  (out_pixel),
    .rd_valid (out_valid),
    .level    (level),
    .full     (fifo_full)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      almost_full <= 1'b0;
      overflow    <= 1'b0;
      frame_done  <= 1'b0;
      x           <= '0;
      y           <= '0;
    end else begin
      almost_full <= (level_nxt >= LW'(DEPTH - AFULL_MARGIN));
      if (in_valid && !push) overflow <= 1'b1;
      frame_done <= pop && last_x && last_y;
      // Position follows the head pixel, so it only moves when the packer takes one.
      if (pop) begin
        if (last_x) begin
          x <= '0;
          y <= last_y ? '0 : y + 1'b1;
        end else begin
          x <= x + 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_shade_output_fifo.sv
// Directed bench for shade_output_fifo; frame height shortened so a full frame stays short.
module tb_shade_output_fifo;

  localparam int DEPTH = 64;
  localparam int SW    = 640;
  localparam int SH    = 4;
  localparam int FRAME = SW * SH;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic [23:0] in_pixel;
  logic [23:0] out_pixel;
  logic        out_valid;
  logic        out_ready;
  logic        out_sof;
  logic        out_eol;
  logic        almost_full;
  logic        overflow;
  logic        frame_done;
  logic [6:0]  level;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  shade_output_fifo #(
    .DEPTH         (DEPTH),
    .COLOR_WIDTH   (8),
    .SCREEN_WIDTH  (SW),
    .SCREEN_HEIGHT (SH),
    .AFULL_MARGIN  (16)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid),
    .in_pixel    (in_pixel),
    .out_pixel   (out_pixel),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_sof     (out_sof),
    .out_eol     (out_eol),
    .almost_full (almost_full),
    .overflow    (overflow),
    .frame_done  (frame_done),
    .level       (level)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; in_pixel = '0;
    tick(); tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL reset_valid: got %b want 0", out_valid); end
    n_cmp++; if (out_pixel !== 24'h0) begin n_bad++; $display("FAIL reset_pixel: got %h want 0", out_pixel); end
    n_cmp++; if (out_sof !== 1'b1) begin n_bad++; $display("FAIL reset_sof: got %b want 1", out_sof); end
    n_cmp++; if (out_eol !== 1'b0) begin n_bad++; $display("FAIL reset_eol: got %b want 0", out_eol); end
    n_cmp++; if (almost_full !== 1'b0) begin n_bad++; $display("FAIL reset_afull: got %b want 0", almost_full); end
    n_cmp++; if (overflow !== 1'b0) begin n_bad++; $display("FAIL reset_ovf: got %b want 0", overflow); end
    n_cmp++; if (frame_done !== 1'b0) begin n_bad++; $display("FAIL reset_fd: got %b want 0", frame_done); end
    n_cmp++; if (level !== 7'd0) begin n_bad++; $display("FAIL reset_level: got %0d want 0", level); end
  endtask

  task automatic test_single();
    do_reset();
    out_ready = 1'b1; in_valid = 1'b1; in_pixel = 24'h112233;
    tick();
    in_valid = 1'b0;
    n_cmp++; if (out_valid !== 1'b1) begin n_bad++; $display("FAIL single_valid: got %b want 1", out_valid); end
    n_cmp++; if (out_pixel !== 24'h112233) begin n_bad++; $display("FAIL single_pixel: got %h want 112233", out_pixel); end
    n_cmp++; if (out_sof !== 1'b1) begin n_bad++; $display("FAIL single_sof: got %b want 1", out_sof); end
    n_cmp++; if (level !== 7'd1) begin n_bad++; $display("FAIL single_level1: got %0d want 1", level); end
    tick();
    n_cmp++; if (level !== 7'd0) begin n_bad++; $display("FAIL single_level0: got %0d want 0", level); end
    n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL single_empty: got %b want 0", out_valid); end
    n_cmp++; if (out_pixel !== 24'h112233) begin n_bad++; $display("FAIL single_hold: got %h want 112233", out_pixel); end
  endtask

  task automatic test_fill_overflow();
    do_reset();
    out_ready = 1'b0;
    for (int i = 0; i < 64; i++) begin
      in_valid = 1'b1; in_pixel = 24'(i);
      tick();
      n_cmp++; if (level !== 7'(i + 1)) begin n_bad++; $display("FAIL fill_level[%0d]: got %0d want %0d", i, level, i + 1); end
      n_cmp++; if (almost_full !== (i + 1 >= 48)) begin n_bad++; $display("FAIL fill_afull[%0d]: got %b want %b", i, almost_full, (i + 1 >= 48)); end
      n_cmp++; if (overflow !== 1'b0) begin n_bad++; $display("FAIL fill_ovf[%0d]: got %b want 0", i, overflow); end
    end
    in_pixel = 24'd64;
    tick();
    in_valid = 1'b0;
    n_cmp++; if (overflow !== 1'b1) begin n_bad++; $display("FAIL drop_ovf: got %b want 1", overflow); end
    n_cmp++; if (level !== 7'd64) begin n_bad++; $display("FAIL drop_level: got %0d want 64", level); end
    out_ready = 1'b1;
    for (int i = 0; i < 64; i++) begin
      n_cmp++; if (out_valid !== 1'b1 || out_pixel !== 24'(i)) begin n_bad++; $display("FAIL drain[%0d]: got v=%b %h want v=1 %h", i, out_valid, out_pixel, 24'(i)); end
      tick();
    end
    n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL drain_end_valid: got %b want 0", out_valid); end
    n_cmp++; if (level !== 7'd0) begin n_bad++; $display("FAIL drain_end_level: got %0d want 0", level); end
    n_cmp++; if (overflow !== 1'b1) begin n_bad++; $display("FAIL ovf_sticky: got %b want 1", overflow); end
    n_cmp++; if (almost_full !== 1'b0) begin n_bad++; $display("FAIL drain_afull: got %b want 0", almost_full); end
    out_ready = 1'b0;
  endtask

  task automatic test_full_stream();
    logic [23:0] exp;
    do_reset();
    out_ready = 1'b0;
    for (int i = 0; i < 64; i++) begin
      in_valid = 1'b1; in_pixel = 24'(100 + i);
      tick();
    end
    out_ready = 1'b1;
    for (int k = 0; k < 10; k++) begin
      in_valid = 1'b1; in_pixel = 24'(200 + k);
      n_cmp++; if (out_pixel !== 24'(100 + k)) begin n_bad++; $display("FAIL fs_head[%0d]: got %h want %h", k, out_pixel, 24'(100 + k)); end
      tick();
      n_cmp++; if (level !== 7'd64) begin n_bad++; $display("FAIL fs_level[%0d]: got %0d want 64", k, level); end
      n_cmp++; if (overflow !== 1'b0) begin n_bad++; $display("FAIL fs_ovf[%0d]: got %b want 0", k, overflow); end
    end
    in_valid = 1'b0;
    for (int k = 0; k < 64; k++) begin
      exp = (k < 54) ? 24'(110 + k) : 24'(200 + k - 54);
      n_cmp++; if (out_valid !== 1'b1 || out_pixel !== exp) begin n_bad++; $display("FAIL fs_drain[%0d]: got v=%b %h want v=1 %h", k, out_valid, out_pixel, exp); end
      tick();
    end
    n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL fs_empty: got %b want 0", out_valid); end
    out_ready = 1'b0;
  endtask

  task automatic test_line_stalls();
    int sent, rcv, cyc;
    logic stall, s_sof, s_eol;
    logic [23:0] s_pix;
    do_reset();
    sent = 0; rcv = 0; cyc = 0; stall = 1'b0; s_pix = '0; s_sof = 1'b0; s_eol = 1'b0;
    while (rcv < SW + 1 && cyc < 5000) begin
      if (stall) begin
        n_cmp++; if (out_valid !== 1'b1 || out_pixel !== s_pix || out_sof !== s_sof || out_eol !== s_eol) begin
          n_bad++; $display("FAIL stall_hold[%0d]: got v=%b %h sof=%b eol=%b want v=1 %h sof=%b eol=%b", rcv, out_valid, out_pixel, out_sof, out_eol, s_pix, s_sof, s_eol);
        end
      end
      out_ready = ($urandom_range(0, 3) != 0);
      in_valid  = !almost_full && (sent < SW + 1);
      in_pixel  = 24'(sent);
      if (in_valid) sent++;
      if (out_valid && out_ready) begin
        n_cmp++; if (out_pixel !== 24'(rcv) || out_eol !== (rcv == SW - 1) || out_sof !== (rcv == 0)) begin
          n_bad++; $display("FAIL line_px[%0d]: got %h sof=%b eol=%b want %h sof=%b eol=%b", rcv, out_pixel, out_sof, out_eol, 24'(rcv), (rcv == 0), (rcv == SW - 1));
        end
        rcv++;
      end
      stall = out_valid && !out_ready;
      s_pix = out_pixel; s_sof = out_sof; s_eol = out_eol;
      tick();
      cyc++;
    end
    in_valid = 1'b0; out_ready = 1'b0;
    n_cmp++; if (rcv !== SW + 1) begin n_bad++; $display("FAIL line_timeout: got %0d pixels want %0d", rcv, SW + 1); end
    n_cmp++; if (overflow !== 1'b0) begin n_bad++; $display("FAIL line_ovf: got %b want 0", overflow); end
  endtask

  task automatic test_frame();
    int sent, rcv, cyc, pulses;
    logic fd_exp;
    do_reset();
    out_ready = 1'b1;
    sent = 0; rcv = 0; cyc = 0; pulses = 0; fd_exp = 1'b0;
    while (rcv < FRAME + 1 && cyc < 10000) begin
      n_cmp++; if (frame_done !== fd_exp) begin n_bad++; $display("FAIL frame_done[%0d]: got %b want %b", rcv, frame_done, fd_exp); end
      if (frame_done === 1'b1) pulses++;
      in_valid = !almost_full && (sent < FRAME + 1);
      in_pixel = 24'(sent);
      if (in_valid) sent++;
      fd_exp = 1'b0;
      if (out_valid) begin
        if (rcv == 0 || rcv == FRAME) begin
          n_cmp++; if (out_sof !== 1'b1) begin n_bad++; $display("FAIL frame_sof[%0d]: got %b want 1", rcv, out_sof); end
        end
        n_cmp++; if (out_pixel !== 24'(rcv)) begin n_bad++; $display("FAIL frame_px[%0d]: got %h want %h", rcv, out_pixel, 24'(rcv)); end
        if (rcv == FRAME - 1) fd_exp = 1'b1;
        rcv++;
      end
      tick();
      cyc++;
    end
    in_valid = 1'b0;
    n_cmp++; if (frame_done !== fd_exp) begin n_bad++; $display("FAIL frame_done_tail: got %b want %b", frame_done, fd_exp); end
    n_cmp++; if (rcv !== FRAME + 1) begin n_bad++; $display("FAIL frame_timeout: got %0d pixels want %0d", rcv, FRAME + 1); end
    n_cmp++; if (pulses !== 1) begin n_bad++; $display("FAIL frame_pulses: got %0d want 1", pulses); end
    out_ready = 1'b0;
  endtask

  task automatic test_reset_mid();
    do_reset();
    out_ready = 1'b0;
    for (int i = 0; i < 65; i++) begin
      in_valid = 1'b1; in_pixel = 24'(i);
      tick();
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    repeat (44) tick();
    out_ready = 1'b0;
    n_cmp++; if (level !== 7'd20) begin n_bad++; $display("FAIL mid_level: got %0d want 20", level); end
    n_cmp++; if (overflow !== 1'b1 || out_sof !== 1'b0) begin n_bad++; $display("FAIL mid_pre: got ovf=%b sof=%b want ovf=1 sof=0", overflow, out_sof); end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL mid_valid: got %b want 0", out_valid); end
    n_cmp++; if (level !== 7'd0) begin n_bad++; $display("FAIL mid_level0: got %0d want 0", level); end
    n_cmp++; if (overflow !== 1'b0) begin n_bad++; $display("FAIL mid_ovf: got %b want 0", overflow); end
    n_cmp++; if (almost_full !== 1'b0) begin n_bad++; $display("FAIL mid_afull: got %b want 0", almost_full); end
    in_valid = 1'b1; in_pixel = 24'hABCDEF;
    tick();
    in_valid = 1'b0;
    n_cmp++; if (out_valid !== 1'b1 || out_pixel !== 24'hABCDEF) begin n_bad++; $display("FAIL mid_push: got v=%b %h want v=1 abcdef", out_valid, out_pixel); end
    n_cmp++; if (out_sof !== 1'b1) begin n_bad++; $display("FAIL mid_sof: got %b want 1", out_sof); end
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; in_pixel = '0;
    test_reset();
    test_single();
    test_fill_overflow();
    test_full_stream();
    test_line_stalls();
    test_frame();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, compared %0d", n_cmp);
    $fatal(1);
  end

endmodule

// File: doc/shade_output_fifo.md
Name: shade_output_fifo

Overview:
- Elastic stage between the shading stage and the AXI-Stream pixel packer.
- The shading pipeline emits pixels with a valid strobe and has no backpressure. This block absorbs them in a first-word-fall-through FIFO and presents them to the packer with a ready/valid handshake.
- Raster position is tracked on the output side, and start-of-frame / end-of-line flags are generated per pixel.
- almost_full throttles ray issue upstream so in-flight pixels always have room.

Parameters:
- DEPTH, 64, FIFO entries; power of two, >= 4.
- COLOR_WIDTH, `COLOR_WIDTH (8), bits per colour channel.
- SCREEN_WIDTH, `SCREEN_WIDTH (640), pixels per line.
- SCREEN_HEIGHT, `SCREEN_HEIGHT (480), lines per frame.
- AFULL_MARGIN, 16, free entries reserved for pixels already in the ray/shade pipeline; must be < DEPTH.

Ports:
- clk  in  1  pixel clock (out_stream_aclk domain)
- rst  in  1  synchronous reset, active-high
- in_valid  in  1  shaded pixel present this cycle (shading valid_out)
- in_pixel  in  3*COLOR_WIDTH  {r,g,b} from shade_out
- out_pixel  out  3*COLOR_WIDTH  head pixel {r,g,b} to packer
- out_valid  out  1  head pixel valid
- out_ready  in  1  packer in_stream_ready
- out_sof  out  1  head pixel is x=0,y=0
- out_eol  out  1  head pixel is x=SCREEN_WIDTH-1
- almost_full  out  1  count >= DEPTH-AFULL_MARGIN; upstream stops issuing rays
- overflow  out  1  sticky: a pixel was dropped
- frame_done  out  1  one-cycle pulse after last pixel of a frame handshakes
- level  out  $clog2(DEPTH+1)  current occupancy

Behaviour:
- Reset state: out_valid=0, out_pixel=0, out_sof=1, out_eol=0, almost_full=0, overflow=0, frame_done=0, level=0. Pointers and x/y are 0.
- Reset asserted mid-operation flushes all contents on the next edge. Stored pixels are discarded, not drained. x/y return to 0 and overflow clears.
- push = in_valid & (level<DEPTH | pop).
- pop = out_valid & out_ready.
- Both push and pop are evaluated in the same cycle.
- Full with simultaneous push and pop: both are accepted and level is unchanged.
- in_valid while full with no pop: the pixel is dropped, overflow is set, level is unchanged.
- Empty with in_valid: out_valid rises the next cycle with that pixel. Latency is 1 clock; there is no combinational path from in_* to out_*.
- Empty with no push: out_valid=0 and out_pixel holds its last value.
- out_pixel, out_sof and out_eol hold stable while out_valid & !out_ready (AXI-Stream rule).
- level is updated as level + push - pop; it is registered and never wraps.
- Read/write pointers are $clog2(DEPTH) bits and wrap modulo DEPTH.
- almost_full is registered and derived from the next-cycle level.
- Raster counters: x is 10 bits, y is 9 bits; they advance on pop only.
  - At x=SCREEN_WIDTH-1: x goes to 0 and y increments.
  - At x=SCREEN_WIDTH-1 and y=SCREEN_HEIGHT-1: y goes to 0 and frame_done pulses the next cycle.
- out_sof = (x==0 & y==0) and out_eol = (x==SCREEN_WIDTH-1). Both are decoded from the registered x/y and refer to the head pixel.
- The block carries no per-pixel position. It relies on upstream emitting pixels strictly in raster order; out-of-order delivery is not detected.

Decomposition:
- Shared package:
  - typedef pixel_t: packed struct {r,g,b} of `COLOR_WIDTH each.
  - SCREEN_WIDTH and SCREEN_HEIGHT remain in common_defs.
- One sub-module: sync_fifo_fwft.
  - Parameters: WIDTH, DEPTH.
  - Ports: clk, rst, wr_en, wr_data, rd_en, rd_data, rd_valid, level, full.
  - Holds storage, pointers and the FWFT head register.
- The wrapper holds:
  - drop/overflow logic
  - almost_full compare
  - x/y raster counters, sof/eol decode, frame_done

Test Plan:
- Reset then one in_valid with in_pixel=0x112233, out_ready=1 -> next cycle out_valid=1, out_pixel=0x112233, out_sof=1. After the pop, level=0 and out_valid=0.
- out_ready=0, push 64 pixels 0..63 on consecutive cycles -> level reaches 64; almost_full rises when level reaches 48; overflow stays 0. Then push pixel 64 -> overflow=1 sticky, level=64. Raise out_ready -> pixels 0..63 emerge in order and pixel 64 never appears.
- Full FIFO, out_ready=1 and in_valid=1 for 10 cycles -> level stays 64, overflow stays 0, and output order is preserved.
- Stream 640 pixels with random out_ready stalls -> out_eol=1 only on the 640th pixel. out_* stay stable across every stall cycle. The 641st pixel has x=0, y=1, out_sof=0.
- Stream a full 640x480 frame plus 1 pixel -> frame_done pulses exactly once, one cycle after pixel 307199 handshakes. Pixel 307200 shows out_sof=1.
- Load 20 pixels, assert rst for 1 cycle mid-stream -> next cycle out_valid=0, level=0, overflow=0. The next pushed pixel shows out_sof=1.
